// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 8-bit alu op codes, 16-bit sequencer op codes
// and the sequencer state enum.
package cpu_pkg;

  localparam int unsigned DW = 8;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_SBC = 4'h3;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'd0,
    OP_SUB16 = 2'd1,
    OP_INC16 = 2'd2,
    OP_DEC16 = 2'd3
  } op16_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq16.sv
// alu_seq16: sequences a 16-bit add/sub/inc/dec as two byte passes through
// an external 8-bit alu (low byte, then high byte with carry chained).
// Optional feature: define ALU_SEQ16_ZERO16_EN to build the zero16 flag;
// otherwise zero16 is tied low.
module alu_seq16
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op16,
  input  logic [15:0]   a,
  input  logic [15:0]   b,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic          carry,
  output logic          zero16,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [3:0]    alu_operation,
  output logic          alu_carry_in,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry
);

  state_t        state, state_nxt;
  op16_t         op_q;
  logic [15:0]   a_q, b_q;
  logic [15:0]   b_eff;
  logic [DW-1:0] lo_q;
  logic          carry_lo;
  logic          is_sub;
  logic          accept;

  assign accept = (state == ST_IDLE) && start;
  assign is_sub = (op_q == OP_SUB16) || (op_q == OP_DEC16);
  // INC/DEC are add/sub of one; b is never looked at for them
  assign b_eff  = ((op_q == OP_INC16) || (op_q == OP_DEC16)) ? 16'h0001 : b_q;
  assign busy   = (state != ST_IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state and byte-pass alu drive
  always_comb begin
    state_nxt     = state;
    alu_op1       = '0;
    alu_op2       = '0;
    alu_operation = ALU_ADD;
    alu_carry_in  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOW;
      ST_LOW: begin
        state_nxt     = ST_HIGH;
        alu_op1       = a_q[7:0];
        alu_op2       = b_eff[7:0];
        alu_operation = is_sub ? ALU_SUB : ALU_ADD;
      end
      ST_HIGH: begin
        state_nxt     = ST_IDLE;
        alu_op1       = a_q[15:8];
        alu_op2       = b_eff[15:8];
        alu_operation = is_sub ? ALU_SBC : ALU_ADC;
        alu_carry_in  = carry_lo;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // operand capture; only an accepted start touches the latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD16;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op16_t'(op16);
    end
  end

  // byte results; result/carry are only committed on the high pass so they
  // stay stable from one completion to the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q     <= '0;
      carry_lo <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_LOW) begin
        lo_q     <= alu_result;
        carry_lo <= alu_carry;
      end
      if (state == ST_HIGH) begin
        result <= {alu_result, lo_q};
        carry  <= alu_carry;
        done   <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ16_ZERO16_EN
  // zero flag from the stored low byte and the live high byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 zero16 <= 1'b0;
    else if (state == ST_HIGH)  zero16 <= (lo_q == '0) && (alu_result == '0);
  end
`else
  assign zero16 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: behavioural 8-bit alu, directed table, random ops
// against a 16-bit arithmetic model, restart/hold/reset sequences.
module tb_alu_seq16;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op16 = 2'd0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, carry, zero16;
  logic [15:0] result;
  logic [7:0]  alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_operation;
  logic        alu_carry_in, alu_carry;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op16(op16), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero16(zero16),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // behavioural 8-bit alu; carry out is the borrow for subtraction
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_operation)
      ALU_ADC: t = {1'b0, alu_op1} + {1'b0, alu_op2} + {8'd0, alu_carry_in};
      ALU_SUB: t = {1'b0, alu_op1} - {1'b0, alu_op2};
      ALU_SBC: t = {1'b0, alu_op1} - {1'b0, alu_op2} - {8'd0, alu_carry_in};
      default: t = {1'b0, alu_op1} + {1'b0, alu_op2};
    endcase
    alu_result = t[7:0];
    alu_carry  = t[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_zero(input logic [15:0] r);
`ifdef ALU_SEQ16_ZERO16_EN
    return (r == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // 16-bit reference: result, carry/borrow out and the low-byte carry
  task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic c, output logic clo);
    logic [16:0] t;
    logic [15:0] yy;
    yy = (op == 2'd2 || op == 2'd3) ? 16'd1 : y;
    if (op == 2'd1 || op == 2'd3) begin
      t   = {1'b0, x} - {1'b0, yy};
      clo = (x[7:0] < yy[7:0]);
    end else begin
      t   = {1'b0, x} + {1'b0, yy};
      clo = ({1'b0, x[7:0]} + {1'b0, yy[7:0]}) > 9'd255;
    end
    r = t[15:0];
    c = t[16];
  endtask

  // one full operation with cycle-by-cycle timing and alu-drive checks
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] x,
                        input logic [15:0] y);
    logic [15:0] er, yy;
    logic ec, eclo, sub;
    model(op, x, y, er, ec, eclo);
    yy  = (op >= 2'd2) ? 16'd1 : y;
    sub = (op == 2'd1 || op == 2'd3);
    @(negedge clk);
    start = 1'b1; op16 = op; a = x; b = y;
    @(posedge clk); #1;                       // after E0: LOW
    start = 1'b0;
    chk({tag, " busy@E0"}, busy, 1);
    chk({tag, " done@E0"}, done, 0);
    chk({tag, " lo drive"}, {alu_op1, alu_op2, alu_operation, 3'b0, alu_carry_in},
        {x[7:0], yy[7:0], (sub ? ALU_SUB : ALU_ADD), 4'b0});
    @(posedge clk); #1;                       // after E1: HIGH
    chk({tag, " busy@E1"}, busy, 1);
    chk({tag, " hi drive"}, {alu_op1, alu_op2, alu_operation, 3'b0, alu_carry_in},
        {x[15:8], yy[15:8], (sub ? ALU_SBC : ALU_ADC), 3'b0, eclo});
    @(posedge clk); #1;                       // after E2: done
    chk({tag, " busy@E2"}, busy, 0);
    chk({tag, " done@E2"}, done, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " zero16"}, zero16, exp_zero(er));
    @(posedge clk); #1;
    chk({tag, " done@E3"}, done, 0);
    chk({tag, " hold"}, {result, 15'd0, carry}, {er, 15'd0, ec});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, res;
    logic        c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] r;
    logic c, clo;
    int done_cnt;

    vecs[0] = '{2'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
    vecs[1] = '{2'd2, 16'hFFFF, 16'hABCD, 16'h0000, 1'b1};
    vecs[2] = '{2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1};
    vecs[3] = '{2'd3, 16'h0100, 16'h5555, 16'h00FF, 1'b0};
    vecs[4] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[5] = '{2'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0};

    // reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst carry", carry, 0);
    chk("rst zero16", zero16, 0);
    chk("idle drive", {alu_op1, alu_op2, alu_operation, alu_carry_in}, {16'h0, ALU_ADD, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    // directed table: constants cross-checked against the model too
    for (int i = 0; i < 6; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, r, c, clo);
      chk($sformatf("vec%0d table", i), {r, 15'd0, c}, {vecs[i].res, 15'd0, vecs[i].c});
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
    end

    // random operations
    for (int i = 0; i < 24; i++)
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(3)), 16'($urandom), 16'($urandom));

    // restart attempts in LOW and HIGH are ignored
    @(negedge clk);
    start = 1'b1; op16 = 2'd0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    a = 16'h7777; b = 16'h0F0F; op16 = 2'd1;  // still high through LOW and HIGH
    done_cnt = 0;
    @(posedge clk); #1; done_cnt += int'(done);
    @(posedge clk); #1; done_cnt += int'(done);
    start = 1'b0;
    chk("restart result", result, 16'h3333);
    @(posedge clk); #1; done_cnt += int'(done);
    @(posedge clk); #1; done_cnt += int'(done);
    chk("restart busy", busy, 0);
    chk("restart dones", done_cnt, 1);

    // start held high: accepted again at E3, one op per 3 cycles
    @(negedge clk);
    start = 1'b1; op16 = 2'd2; a = 16'h0041; b = 16'h0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2 || k == 5) chk($sformatf("hold done k%0d", k), done, 1);
      else                  chk($sformatf("hold done k%0d", k), done, 0);
      if (k == 3) chk("hold busy@E3", busy, 1);
    end
    start = 1'b0;
    chk("hold result", result, 16'h0042);
    @(posedge clk); #1;

    // reset during HIGH aborts
    @(negedge clk);
    start = 1'b1; op16 = 2'd0; a = 16'h4000; b = 16'h0001;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;                       // in HIGH
    chk("pre-rst busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("async rst", {busy, done, carry, zero16, result}, 20'h0);
    chk("async rst drive", {alu_op1, alu_op2, alu_operation, alu_carry_in}, {16'h0, ALU_ADD, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; done_cnt += int'(done | busy); end
    chk("post-rst quiet", done_cnt, 0);
    chk("post-rst result", result, 0);
    run_op("fresh", 2'd0, 16'h1234, 16'h0001);
    chk("fresh value", result, 16'h1235);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 No parameters; 8-bit datapath width and op encodings are fixed by the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op16  input  2  0=ADD16, 1=SUB16, 2=INC16, 3=DEC16.
REQ-006 a  input  16  first operand.
REQ-007 b  input  16  second operand; ignored for INC16/DEC16.
REQ-008 busy  output  1  high while the sequence runs.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 result  output  16  registered 16-bit result.
REQ-011 carry  output  1  final carry/borrow out of bit 15.
REQ-012 zero16  output  1  result==0 (see Configuration).
REQ-013 alu_op1, alu_op2  output  8 each  byte operands to the 8-bit alu.
REQ-014 alu_operation  output  4  alu op code.
REQ-015 alu_carry_in  output  1  carry into alu ADC/SBC.
REQ-016 alu_result  input  8  alu result byte.
REQ-017 alu_carry  input  1  alu carry/borrow out.

Function
REQ-018 States: IDLE, LOW, HIGH. IDLE->LOW on start=1, latching a, b, op16. LOW->HIGH always. HIGH->IDLE always.
REQ-019 Effective b: ADD16/SUB16 use b; INC16/DEC16 use 16'h0001.
REQ-020 LOW drives latched a[7:0] and b_eff[7:0], op ALU_ADD (ADD16/INC16) or ALU_SUB (SUB16/DEC16), alu_carry_in=0. It stores alu_result into the low byte and alu_carry into an internal carry_lo.
REQ-021 HIGH drives a[15:8] and b_eff[15:8], op ALU_ADC or ALU_SBC, alu_carry_in=carry_lo. It stores alu_result into the high byte and alu_carry into carry.
REQ-022 In IDLE: alu_op1=alu_op2=0, alu_operation=ALU_ADD, alu_carry_in=0.
REQ-023 Latency: with start sampled at edge E0, busy=1 from E0 to E2, and done=1 for exactly the cycle following E2.
REQ-024 result, carry and zero16 hold their values from E2 until the next completion or reset.
REQ-025 start while busy is ignored with no effect. Earliest accepted restart is at E3, giving back-to-back throughput of one op per 3 cycles.
REQ-026 start is sampled at E2 only if the state is IDLE; it is not, so start held high is next accepted at E3.
REQ-027 Wrap-around: 16'hFFFF+1 -> 16'h0000 with carry=1; 16'h0000-1 -> 16'hFFFF with carry=1 (borrow).

Reset
REQ-028 rst_n low forces IDLE, busy=0, done=0, result=16'h0000, carry=0, zero16=0 and carry_lo=0 immediately, independent of clk.
REQ-029 Reset asserted in LOW or HIGH aborts the operation; no done is produced after release.

Configuration
REQ-030 Macro ALU_SEQ16_ZERO16_EN defined: zero16 is registered at E2 as (final 16-bit result==0), using the registered low byte and the live alu_result.
REQ-031 Macro undefined: zero16 is tied 0 and no zero-detect logic exists.

Structure
REQ-032 A shared package cpu_pkg holds the 4-bit alu op constants (ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC), the 2-bit op16 encodings and the 3-state enum.
REQ-033 The block is a single module with no sub-module. The alu is instantiated by the parent, not inside alu_seq16.

Verification
REQ-034 The bench uses a behavioural 8-bit alu model honouring alu_carry_in. Each scenario checks done timing against REQ-023.
REQ-035 ADD16 a=16'h00FF b=16'h0001 -> result 16'h0100, carry 0, zero16 0, done one cycle after E2.
REQ-036 INC16 a=16'hFFFF -> result 16'h0000, carry 1, zero16 1 (with macro) or 0 (without).
REQ-037 SUB16 a=16'h0000 b=16'h0001 -> result 16'hFFFF, carry 1. DEC16 a=16'h0100 -> 16'h00FF, carry 0.
REQ-038 start re-pulsed in LOW and HIGH with different operands -> ignored; result reflects the first operands only, and a single done pulse.
REQ-039 rst_n low during HIGH -> outputs zero asynchronously, state IDLE, no done after release; a fresh ADD16 16'h1234+16'h0001 then yields 16'h1235.
